// File: rtl/vecmac_issue_ctrl.sv
// vecmac_issue_ctrl: operand issue, credit accounting and result buffering
// for the mul8x8x8_wallace dot-product MAC.
//   - Operand beats are accepted on s_* and issued one cycle later on mac_in_*.
//   - The MAC has no backpressure, so each accepted beat consumes a credit that
//     reserves a result FIFO slot; the credit returns when the result pops.
//   - flush drains all in-flight and buffered results, then pulses flush_done.
// Optional build macro: VECMAC_LAT_CHECK_EN
//   When defined, a LATENCY-deep shadow of issued beats is compared against
//   mac_out_valid and any disagreement sets the sticky err_lat flag.
//   When undefined, err_lat is tied to 0.
module vecmac_issue_ctrl #(
    parameter int BUSW      = 64,
    parameter int SUMW      = 19,
    parameter int LATENCY   = 8,
    parameter int RES_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BUSW-1:0] s_a,
    input  logic [BUSW-1:0] s_b,
    output logic            mac_in_valid,
    output logic [BUSW-1:0] mac_in_a,
    output logic [BUSW-1:0] mac_in_b,
    input  logic            mac_out_valid,
    input  logic [SUMW-1:0] mac_out_sum,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [SUMW-1:0] m_data,
    input  logic            flush,
    output logic            flush_done,
    output logic            err_ovf,
    output logic            err_lat
);

    localparam int CW = $clog2(RES_DEPTH + 1);  // credit counter
    localparam int FW = $clog2(RES_DEPTH + 1);  // FIFO occupancy
    localparam int PW = $clog2(RES_DEPTH);      // FIFO pointer
    localparam int IW = $clog2(RES_DEPTH + 1);  // in-flight count, bounded by credits

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            out_en_q;
    logic [CW-1:0]   credits_q, credits_d;
    logic            mac_in_valid_q, mac_in_valid_d;
    logic [BUSW-1:0] mac_in_a_q, mac_in_a_d;
    logic [BUSW-1:0] mac_in_b_q, mac_in_b_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]   count_q, count_d;
    logic            m_valid_q, m_valid_d;
    logic [IW-1:0]   in_flight_q, in_flight_d;
    logic            flush_done_q, flush_done_d;
    logic            err_ovf_q, err_ovf_d;

    logic [SUMW-1:0] mem [RES_DEPTH];

    logic s_hs;
    logic m_hs;
    logic fifo_full;
    logic push;
    logic pop;
    logic drain_done;

    // out_en_q keeps s_ready low through reset; it rises on the first clean edge.
    assign s_ready = out_en_q && (credits_q != '0) && (state_q != ST_DRAIN);

    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid_q && m_ready;
    assign fifo_full = (count_q == FW'(RES_DEPTH));
    assign pop       = m_hs;
    // A result arriving at full is only storable if a slot frees in the same cycle.
    assign push      = mac_out_valid && (!fifo_full || pop);

    assign drain_done = (in_flight_q == '0) && (count_q == '0) && !mac_in_valid_q;

    // Datapath next-state: issue register, credits, FIFO pointers, in-flight count.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        mac_in_valid_d = s_hs;
        mac_in_a_d     = mac_in_a_q;
        mac_in_b_d     = mac_in_b_q;
        credits_d      = credits_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        in_flight_d    = in_flight_q;
        err_ovf_d      = err_ovf_q;

        if (s_hs) begin
            mac_in_a_d = s_a;
            mac_in_b_d = s_b;
        end

        if (s_hs && !m_hs) begin
            credits_d = credits_q - CW'(1);
        end else if (!s_hs && m_hs && (credits_q != CW'(RES_DEPTH))) begin
            credits_d = credits_q + CW'(1);
        end

        // Pointers wrap naturally because RES_DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        if (push && !pop) begin
            count_d = count_q + FW'(1);
        end else if (!push && pop) begin
            count_d = count_q - FW'(1);
        end

        // Spurious results must not wrap the in-flight count below zero.
        if (mac_in_valid_q && !mac_out_valid) begin
            in_flight_d = in_flight_q + IW'(1);
        end else if (!mac_in_valid_q && mac_out_valid && (in_flight_q != '0)) begin
            in_flight_d = in_flight_q - IW'(1);
        end

        if (mac_out_valid && fifo_full && !pop) err_ovf_d = 1'b1;
    end

    // m_valid is registered from the next occupancy so it tracks !empty exactly.
    assign m_valid_d = (count_d != '0);

    // Flow-control FSM: next state and the flush_done pulse.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush)     state_d = ST_DRAIN;
                else if (s_hs) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Once entered, the drain completes even if flush drops.
                if (drain_done) begin
                    state_d      = ST_IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            out_en_q       <= 1'b0;
            credits_q      <= CW'(RES_DEPTH);
            mac_in_valid_q <= 1'b0;
            mac_in_a_q     <= '0;
            mac_in_b_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            m_valid_q      <= 1'b0;
            in_flight_q    <= '0;
            flush_done_q   <= 1'b0;
            err_ovf_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_en_q       <= 1'b1;
            credits_q      <= credits_d;
            mac_in_valid_q <= mac_in_valid_d;
            mac_in_a_q     <= mac_in_a_d;
            mac_in_b_q     <= mac_in_b_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            m_valid_q      <= m_valid_d;
            in_flight_q    <= in_flight_d;
            flush_done_q   <= flush_done_d;
            err_ovf_q      <= err_ovf_d;
        end
    end

    // Result storage written on every accepted MAC result.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; pointers and count define validity, so stale contents are never observed.
        if (push) mem[wr_ptr_q] <= mac_out_sum;
    end

`ifdef VECMAC_LAT_CHECK_EN
    logic [LATENCY-1:0] lat_sr_q, lat_sr_d;
    logic               err_lat_q, err_lat_d;

    // Shadow of issued beats; the oldest tap predicts mac_out_valid this cycle.
    always_comb begin
        lat_sr_d[0] = mac_in_valid_q;
        for (int i = 1; i < LATENCY; i++) begin
            lat_sr_d[i] = lat_sr_q[i-1];
        end
        err_lat_d = err_lat_q || (mac_out_valid != lat_sr_q[LATENCY-1]);
    end

    // Latency-check registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_sr_q  <= '0;
            err_lat_q <= 1'b0;
        end else begin
            lat_sr_q  <= lat_sr_d;
            err_lat_q <= err_lat_d;
        end
    end

    assign err_lat = err_lat_q;
`else
    assign err_lat = 1'b0;
`endif

    assign mac_in_valid = mac_in_valid_q;
    assign mac_in_a     = mac_in_a_q;
    assign mac_in_b     = mac_in_b_q;
    assign m_valid      = m_valid_q;
    // Drive zero while empty so the unreset array never leaks onto the port.
    assign m_data       = m_valid_q ? mem[rd_ptr_q] : '0;
    assign flush_done   = flush_done_q;
    assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_vecmac_issue_ctrl.sv
// tb_vecmac_issue_ctrl: directed bench for vecmac_issue_ctrl with a behavioural
// fixed-latency MAC stub. Results are scored against a dot-product model and
// hand-computed constants.
module tb_vecmac_issue_ctrl;

    localparam int BUSW      = 64;
    localparam int SUMW      = 19;
    localparam int LATENCY   = 8;
    localparam int RES_DEPTH = 16;
`ifdef VECMAC_LAT_CHECK_EN
    localparam logic EXP_LAT = 1'b1;
`else
    localparam logic EXP_LAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [BUSW-1:0] s_a;
    logic [BUSW-1:0] s_b;
    logic            mac_in_valid;
    logic [BUSW-1:0] mac_in_a;
    logic [BUSW-1:0] mac_in_b;
    logic            mac_out_valid;
    logic [SUMW-1:0] mac_out_sum;
    logic            m_valid;
    logic            m_ready;
    logic [SUMW-1:0] m_data;
    logic            flush;
    logic            flush_done;
    logic            err_ovf;
    logic            err_lat;
    logic            inject;

    vecmac_issue_ctrl #(
        .BUSW(BUSW), .SUMW(SUMW), .LATENCY(LATENCY), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mac_in_valid(mac_in_valid), .mac_in_a(mac_in_a), .mac_in_b(mac_in_b),
        .mac_out_valid(mac_out_valid), .mac_out_sum(mac_out_sum),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .flush(flush), .flush_done(flush_done),
        .err_ovf(err_ovf), .err_lat(err_lat)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [SUMW-1:0] dot8(input logic [BUSW-1:0] a, input logic [BUSW-1:0] b);
        logic [SUMW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc += SUMW'(a[8*i +: 8]) * SUMW'(b[8*i +: 8]);
        end
        return acc;
    endfunction

    function automatic logic [BUSW-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Behavioural MAC: fixed LATENCY from in_valid to out_valid, reset with the DUT.
    logic [LATENCY-1:0] stub_v;
    logic [SUMW-1:0]    stub_s [LATENCY];
    always @(posedge clk) begin
        if (!rst_n) stub_v <= '0;
        else        stub_v <= {stub_v[LATENCY-2:0], mac_in_valid};
        stub_s[0] <= dot8(mac_in_a, mac_in_b);
        for (int i = 1; i < LATENCY; i++) stub_s[i] <= stub_s[i-1];
    end
    assign mac_out_valid = stub_v[LATENCY-1] | inject;
    assign mac_out_sum   = stub_s[LATENCY-1];

    // Scoreboard: handshakes are observed on the falling edge, ahead of the rising edge that completes them.
    logic [SUMW-1:0] exp_q [$];
    int acc_cnt = 0;
    int rx_cnt  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (s_valid && s_ready) begin
                exp_q.push_back(dot8(s_a, s_b));
                acc_cnt++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("rx_unexpected", 64'(exp_q.size()), 1);
                else                   check("rx_data", 64'(m_data), 64'(exp_q.pop_front()));
                rx_cnt++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rx(input int target, input int budget, input string tag);
        int k = 0;
        while (rx_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 64'(rx_cnt), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [BUSW-1:0] ra [20];
        logic [BUSW-1:0] rb [20];
        int   idx, base_rx, stalls, gaps, pulses, done_rx, k;
        logic acc;

        s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
        flush = 1'b0; inject = 1'b0; rst_n = 1'b0;

        // Reset and idle
        step(3);
        check("rst_s_ready", 64'(s_ready), 0);
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_mac_in_valid", 64'(mac_in_valid), 0);
        rst_n = 1'b1;
        step(1);
        check("post_rst_s_ready", 64'(s_ready), 1);
        step(5);
        check("idle_m_valid", 64'(m_valid), 0);
        check("idle_mac_in_valid", 64'(mac_in_valid), 0);
        check("idle_s_ready", 64'(s_ready), 1);
        check("idle_err_ovf", 64'(err_ovf), 0);
        check("idle_err_lat", 64'(err_lat), 0);

        // Single all-ones beat: issue timing and end-to-end latency
        m_ready = 1'b1; s_valid = 1'b1; s_a = '1; s_b = '1;
        step(1);
        s_valid = 1'b0;
        check("issue_valid", 64'(mac_in_valid), 1);
        check("issue_a", mac_in_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("issue_b", mac_in_b, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1);
        check("issue_pulse_end", 64'(mac_in_valid), 0);
        check("issue_hold_a", mac_in_a, 64'hFFFF_FFFF_FFFF_FFFF);
        step(7);
        check("lat_not_yet", 64'(m_valid), 0);
        step(1);
        check("lat_m_valid", 64'(m_valid), 1);
        check("lat_m_data", 64'(m_data), 520200);
        step(1);
        check("pop_empty", 64'(m_valid), 0);

        // Mixed-lane beat with a hand-computed dot product
        base_rx = rx_cnt;
        s_valid = 1'b1; s_a = 64'h0123_4567_89AB_CDEF; s_b = 64'hFEDC_BA98_7654_3210;
        step(1);
        s_valid = 1'b0;
        k = 0;
        while (!m_valid && k < 20) begin step(1); k++; end
        check("lanes_m_valid", 64'(m_valid), 1);
        check("lanes_m_data", 64'(m_data), 81048);
        wait_rx(base_rx + 1, 5, "lanes_rx");

        // Backpressure: 20 beats offered, only RES_DEPTH credits available
        for (int i = 0; i < 20; i++) begin ra[i] = rand64(); rb[i] = rand64(); end
        m_ready = 1'b0; base_rx = rx_cnt; idx = 0;
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1; s_a = ra[idx]; s_b = rb[idx];
            acc = s_ready;
            step(1);
            if (acc) idx++;
        end
        check("stall_accepted", 64'(idx), 16);
        check("stall_s_ready", 64'(s_ready), 0);
        check("stall_m_valid", 64'(m_valid), 1);
        m_ready = 1'b1;
        k = 0;
        while (idx < 20 && k < 200) begin
            s_valid = 1'b1; s_a = ra[idx]; s_b = rb[idx];
            acc = s_ready;
            step(1);
            if (acc) idx++;
            k++;
        end
        s_valid = 1'b0;
        wait_rx(base_rx + 20, 100, "stall_rx_count");
        check("stall_err_ovf", 64'(err_ovf), 0);

        // Full throttle: 4096 beats, no stalls, results back-to-back
        base_rx = rx_cnt; stalls = 0; gaps = 0; m_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            s_valid = 1'b1; s_a = rand64(); s_b = rand64();
            if (!s_ready) stalls++;
            if (rx_cnt > base_rx && rx_cnt < base_rx + 4096 && !m_valid) gaps++;
            step(1);
        end
        s_valid = 1'b0;
        k = 0;
        while (rx_cnt < base_rx + 4096 && k < 100) begin
            if (rx_cnt > base_rx && !m_valid) gaps++;
            step(1);
            k++;
        end
        check("throttle_stalls", 64'(stalls), 0);
        check("throttle_gaps", 64'(gaps), 0);
        check("throttle_rx", 64'(rx_cnt - base_rx), 4096);

        // Flush after 7 beats with m_ready toggling
        base_rx = rx_cnt; idx = 0; k = 0;
        while (idx < 7 && k < 50) begin
            s_valid = 1'b1; s_a = rand64(); s_b = rand64();
            acc = s_ready;
            m_ready = ~m_ready;
            step(1);
            if (acc) idx++;
            k++;
        end
        s_valid = 1'b0; flush = 1'b1;
        step(1);
        check("flush_s_ready", 64'(s_ready), 0);
        pulses = 0; done_rx = -1;
        for (int c = 0; c < 100; c++) begin
            if (c == 2) flush = 1'b0;
            m_ready = ~m_ready;
            step(1);
            if (flush_done) begin
                pulses++;
                if (done_rx < 0) done_rx = rx_cnt - base_rx;
            end
        end
        check("flush_pulses", 64'(pulses), 1);
        check("flush_done_after_rx", 64'(done_rx), 7);
        check("flush_idle_s_ready", 64'(s_ready), 1);
        check("flush_m_valid", 64'(m_valid), 0);

        // Flush held high in IDLE: repeated drains, one pulse each
        m_ready = 1'b1; flush = 1'b1;
        step(1);
        check("hold_drain_fd0", 64'(flush_done), 0);
        check("hold_drain_s_ready", 64'(s_ready), 0);
        step(1);
        check("hold_drain_fd1", 64'(flush_done), 1);
        check("hold_idle_s_ready", 64'(s_ready), 1);
        step(1);
        check("hold_redrain_fd0", 64'(flush_done), 0);
        step(1);
        check("hold_redrain_fd1", 64'(flush_done), 1);
        flush = 1'b0;
        step(1);
        check("hold_end_fd", 64'(flush_done), 0);
        check("hold_end_s_ready", 64'(s_ready), 1);

        // FIFO full, then a spurious MAC result
        check("pre_inject_err_lat", 64'(err_lat), 0);
        m_ready = 1'b0; base_rx = rx_cnt; idx = 0; k = 0;
        while (idx < 16 && k < 40) begin
            s_valid = 1'b1; s_a = rand64(); s_b = rand64();
            acc = s_ready;
            step(1);
            if (acc) idx++;
            k++;
        end
        s_valid = 1'b0;
        step(10);
        check("full_m_valid", 64'(m_valid), 1);
        check("full_s_ready", 64'(s_ready), 0);
        check("full_err_ovf", 64'(err_ovf), 0);
        inject = 1'b1;
        step(1);
        inject = 1'b0;
        check("inject_err_ovf", 64'(err_ovf), 1);
        check("inject_err_lat", 64'(err_lat), 64'(EXP_LAT));
        m_ready = 1'b1;
        wait_rx(base_rx + 16, 60, "full_rx_count");
        step(2);
        check("full_dropped_extra", 64'(m_valid), 0);
        check("sticky_err_ovf", 64'(err_ovf), 1);
        check("sticky_err_lat", 64'(err_lat), 64'(EXP_LAT));

        // Reset with beats in flight: everything discarded, sticky flags cleared
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_a = rand64(); s_b = rand64();
            step(1);
        end
        s_valid = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("rerst_err_ovf", 64'(err_ovf), 0);
        check("rerst_err_lat", 64'(err_lat), 0);
        check("rerst_s_ready", 64'(s_ready), 1);
        base_rx = rx_cnt;
        step(15);
        check("rerst_m_valid", 64'(m_valid), 0);
        check("rerst_mac_in_valid", 64'(mac_in_valid), 0);
        check("rerst_rx", 64'(rx_cnt - base_rx), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
